// File: rtl/pio_edge_capture_pkg.sv
// Shared constants for the PIO edge-capture block: register map, counter width
// and parameter defaults.
package pio_edge_capture_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;
  localparam logic [2:0] ADDR_EVT_CNT  = 3'd6;
  localparam logic [2:0] ADDR_RAW      = 3'd7;

  localparam int EVT_W = 16;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_W  = 8;

endpackage

// File: rtl/pio_edge_capture_bit_filter.sv
// Single-bit input conditioning: SYNC_STAGES-deep synchroniser followed by a
// counter-based debounce that only commits a level once it has held long enough.
module pio_bit_filter
  import pio_edge_capture_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic [DEBOUNCE_W-1:0] debounce,
  output logic                  sync,
  output logic                  filt
);

  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;

  assign sync = sync_q[SYNC_STAGES-1];
  assign filt = filt_q;

  // Counter runs while sync disagrees with filt; it wraps freely if the
  // threshold is lowered below the current count.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == debounce) begin
      filt_d = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pio_edge_capture.sv
// Avalon-MM PIO with per-bit synchronise/debounce, rising/falling edge capture,
// maskable level interrupt and a saturating event counter.
module pio_edge_capture
  import pio_edge_capture_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

  logic [WIDTH-1:0]      sync_s, filt_s, detect_s, clr_s;
  logic [WIDTH-1:0]      filt_dly_q, filt_dly_d;
  logic [WIDTH-1:0]      rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0]      irq_mask_q, irq_mask_d, edge_cap_q, edge_cap_d;
  logic [DEBOUNCE_W-1:0] debounce_q, debounce_d;
  logic [EVT_W-1:0]      evt_q, evt_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  wr_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_bit_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_filter (
      .clk     (clk),
      .reset   (reset),
      .din     (in_port[i]),
      .debounce(debounce_q),
      .sync    (sync_s[i]),
      .filt    (filt_s[i])
    );
  end

  function automatic logic [31:0] zext_w(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign wr_s     = chipselect & ~write_n;
  assign detect_s = (filt_s & ~filt_dly_q & rise_en_q) | (~filt_s & filt_dly_q & fall_en_q);
  assign clr_s    = (wr_s && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;
  assign irq      = |(edge_cap_q & irq_mask_q);
  assign readdata = readdata_q;

  // Register writes, capture update and event counting.
  always_comb begin
    filt_dly_d = filt_s;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_mask_d = irq_mask_q;
    debounce_d = debounce_q;
    edge_cap_d = (edge_cap_q & ~clr_s) | detect_s;
    if (wr_s) begin
      case (address)
        ADDR_RISE_EN:  rise_en_d  = writedata[WIDTH-1:0];
        ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
        ADDR_FALL_EN:  fall_en_d  = writedata[WIDTH-1:0];
        ADDR_DEBOUNCE: debounce_d = writedata[DEBOUNCE_W-1:0];
        default:       rise_en_d  = rise_en_q;
      endcase
    end else begin
      rise_en_d = rise_en_q;
    end
    // A clear that lands with a new event keeps that event counted.
    if (wr_s && (address == ADDR_EVT_CNT)) begin
      evt_d = (|detect_s) ? EVT_ONE : '0;
    end else if ((|detect_s) && (evt_q != {EVT_W{1'b1}})) begin
      evt_d = evt_q + EVT_ONE;
    end else begin
      evt_d = evt_q;
    end
  end

  // Read mux; result is registered so readdata lags address by one cycle.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d = zext_w(filt_s);
      ADDR_RISE_EN:  readdata_d = zext_w(rise_en_q);
      ADDR_IRQ_MASK: readdata_d = zext_w(irq_mask_q);
      ADDR_EDGE_CAP: readdata_d = zext_w(edge_cap_q);
      ADDR_FALL_EN:  readdata_d = zext_w(fall_en_q);
      ADDR_DEBOUNCE: readdata_d[DEBOUNCE_W-1:0] = debounce_q;
      ADDR_EVT_CNT:  readdata_d[EVT_W-1:0] = evt_q;
      ADDR_RAW:      readdata_d = zext_w(sync_s);
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_dly_q <= '0;
      rise_en_q  <= '1;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      debounce_q <= '0;
      evt_q      <= '0;
      readdata_q <= '0;
    end else begin
      filt_dly_q <= filt_dly_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      debounce_q <= debounce_d;
      evt_q      <= evt_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_pio_edge_capture.sv
// Directed bench for pio_edge_capture (default parameters): bus access,
// debounce timing, edge capture, W1C, event counter and reset behaviour.
module tb_pio_edge_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  pio_edge_capture dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input string tag, input logic [31:0] exp);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 32'd0;
    wait_cycles(2);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset = 1'b0;

    bus_read(3'd1, "rst_rise_en", 32'hFFFF_FFFF);
    bus_read(3'd2, "rst_irq_mask", 32'd0);
    bus_read(3'd3, "rst_edge_cap", 32'd0);
    bus_read(3'd4, "rst_fall_en", 32'd0);
    bus_read(3'd5, "rst_debounce", 32'd0);
    bus_read(3'd6, "rst_evt", 32'd0);

    // Basic rising edge on bit 0 with DEBOUNCE=0
    in_port = 32'h1;
    wait_cycles(6);
    bus_read(3'd3, "rise_cap", 32'h1);
    bus_read(3'd6, "rise_evt", 32'h1);
    check("irq_masked", {31'd0, irq}, 32'd0);
    bus_write(3'd2, 32'h1);
    check("irq_unmasked", {31'd0, irq}, 32'd1);
    bus_read(3'd0, "data_bit0", 32'h1);
    bus_read(3'd7, "raw_bit0", 32'h1);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read(3'd0, "data_ro", 32'h1);
    bus_write(3'd3, 32'h1);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    bus_write(3'd6, 32'd0);
    bus_read(3'd6, "evt_clear", 32'd0);

    // Falling-edge only on bit 7
    bus_write(3'd1, 32'd0);
    bus_write(3'd4, 32'h80);
    in_port = 32'h81;
    wait_cycles(6);
    bus_read(3'd3, "rise_disabled", 32'd0);
    in_port = 32'h01;
    wait_cycles(6);
    bus_read(3'd3, "fall_cap", 32'h80);
    bus_write(3'd4, 32'd0);
    bus_read(3'd3, "cap_kept_after_en_clr", 32'h80);
    bus_read(3'd6, "fall_evt", 32'h1);
    bus_write(3'd3, 32'h80);
    bus_read(3'd3, "fall_w1c", 32'd0);

    // Debounce = 4: glitch rejected, long pulse accepted 5 cycles after sync
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'd0);
    bus_write(3'd5, 32'd4);
    bus_read(3'd5, "debounce_rd", 32'd4);
    in_port = 32'h21;
    wait_cycles(3);
    in_port = 32'h01;
    wait_cycles(10);
    bus_read(3'd0, "glitch_data", 32'h01);
    bus_read(3'd3, "glitch_cap", 32'd0);
    address = 3'd0;
    in_port = 32'h21;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("pulse_not_yet", {31'd0, readdata[5]}, 32'd0);
      if (i == 8) check("pulse_filt", {31'd0, readdata[5]}, 32'd1);
    end
    in_port = 32'h01;
    wait_cycles(15);
    bus_read(3'd3, "pulse_cap", 32'h20);
    bus_read(3'd6, "pulse_evt", 32'h1);
    check("irq_other_bit", {31'd0, irq}, 32'd0);
    bus_write(3'd3, 32'h20);

    // Simultaneous clear and new edge on bit 0
    bus_write(3'd5, 32'd0);
    in_port = 32'h00;
    wait_cycles(6);
    in_port = 32'h03;
    wait_cycles(6);
    bus_read(3'd3, "cap_3", 32'h3);
    in_port = 32'h02;
    wait_cycles(6);
    in_port = 32'h03;
    wait_cycles(3);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, "w1c_vs_edge", 32'h3);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, "w1c_plain", 32'h2);
    in_port = 32'h02;
    wait_cycles(6);
    in_port = 32'h03;
    wait_cycles(3);
    bus_write(3'd6, 32'd0);
    bus_read(3'd6, "evt_clear_vs_edge", 32'h1);

    // Event counter saturation: events every cycle on bit 0
    bus_write(3'd4, 32'h1);
    for (int i = 0; i < 65600; i++) begin
      in_port[0] = ~in_port[0];
      tick();
    end
    wait_cycles(6);
    bus_read(3'd6, "evt_sat", 32'h0000_FFFF);
    in_port[0] = ~in_port[0];
    wait_cycles(6);
    bus_read(3'd6, "evt_sat_hold", 32'h0000_FFFF);
    bus_write(3'd6, 32'd0);
    bus_read(3'd6, "evt_sat_clr", 32'd0);

    // Reset in the middle of a DEBOUNCE=8 count
    in_port = 32'h0;
    wait_cycles(6);
    check("irq_pre_reset", {31'd0, irq}, 32'd1);
    bus_write(3'd5, 32'd8);
    in_port = 32'h08;
    wait_cycles(4);
    reset = 1'b1;
    #1;
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_readdata", readdata, 32'd0);
    wait_cycles(2);
    check("midrst_readdata_hold", readdata, 32'd0);
    reset   = 1'b0;
    address = 3'd0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) check("rel_data_early", readdata, 32'd0);
      if (i == 4) check("rel_data", readdata, 32'h08);
    end
    bus_read(3'd1, "rel_rise_en", 32'hFFFF_FFFF);
    bus_read(3'd2, "rel_irq_mask", 32'd0);
    bus_read(3'd4, "rel_fall_en", 32'd0);
    bus_read(3'd5, "rel_debounce", 32'd0);
    bus_read(3'd3, "rel_cap", 32'h08);
    bus_read(3'd6, "rel_evt", 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pio_edge_capture.md
PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

Interface
REQ-001 Parameter WIDTH, default 32, input/register bit count; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 2..4.
REQ-003 Parameter DEBOUNCE_W, default 8, debounce threshold/counter width; legal range 1..16.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  3  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  registered read data.
REQ-011 in_port  in  WIDTH  asynchronous input pins.
REQ-012 irq  out  1  level interrupt.

Function
REQ-013 Write strobe: wr = chipselect & ~write_n; reads need no strobe; readdata = register selected by address, one cycle after address is presented, every cycle.
REQ-014 Register map:
- 0 DATA (RO): filtered value.
- 1 RISE_EN (RW): per-bit rising-edge enable.
- 2 IRQ_MASK (RW).
- 3 EDGE_CAPTURE (W1C).
- 4 FALL_EN (RW).
- 5 DEBOUNCE (RW): DEBOUNCE_W bits.
- 6 EVENT_COUNT (RO, 16 bits): any write clears.
- 7 RAW (RO): synchroniser output.
REQ-015 Unimplemented bits read 0; writes to RO addresses 0 and 7 are ignored.
REQ-016 Each in_port bit passes through a SYNC_STAGES-deep flop chain to produce sync.
REQ-017 Per-bit debounce, evaluated each cycle:
- sync == filt: cnt <= 0.
- else if cnt == DEBOUNCE: filt <= sync, cnt <= 0.
- else: cnt <= cnt + 1.
REQ-018 Debounce latency: filt follows a stable sync change after exactly DEBOUNCE+1 cycles; DEBOUNCE=0 gives 1 cycle; a pulse on sync shorter than DEBOUNCE+1 cycles never reaches filt.
REQ-019 Writing DEBOUNCE mid-count takes effect the next cycle; counters are not cleared; if cnt > new DEBOUNCE, the counter continues to wrap naturally at 2^DEBOUNCE_W.
REQ-020 filt_d = filt delayed one cycle; detect = (filt & ~filt_d & RISE_EN) | (~filt & filt_d & FALL_EN).
REQ-021 EDGE_CAPTURE next = (EDGE_CAPTURE & ~clr) | detect, where clr = writedata[WIDTH-1:0] when wr & address==3, else 0; a simultaneous detect and clear on the same bit leaves the bit set.
REQ-022 irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers, no added latency.
REQ-023 EVENT_COUNT increments by 1 in each cycle where |detect; it saturates at 0xFFFF; a write to address 6 coincident with an event loads 1.
REQ-024 Clearing RISE_EN/FALL_EN does not clear already-captured bits.

Reset
REQ-025 reset asserted asynchronously forces:
- sync chain, filt, filt_d, cnt, EDGE_CAPTURE, IRQ_MASK, FALL_EN, DEBOUNCE, EVENT_COUNT, readdata = 0.
- RISE_EN = all ones (rising-edge default).
REQ-026 While reset is asserted, irq = 0; no edge is detected in the first cycle after deassertion, because filt and filt_d both start at 0.
REQ-027 Reset mid-debounce discards the count; input high at release reaches filt after SYNC_STAGES+1 cycles (DEBOUNCE=0) and produces one rising edge.

Structure
REQ-028 Shared package pio_edge_capture_pkg holds:
- register address constants ADDR_DATA..ADDR_RAW.
- EVENT_COUNT width (16).
- parameter default values.
REQ-029 One sub-module, pio_bit_filter (synchroniser + debounce for a single bit), instantiated WIDTH times by generate; edge, capture, register and bus logic stay in the top.

Verification
REQ-030 Reset release, in_port=0x1, WIDTH=32, DEBOUNCE=0 -> EDGE_CAPTURE=0x1, EVENT_COUNT=1; irq=0 until IRQ_MASK=0x1 written, then irq=1.
REQ-031 DEBOUNCE=4, 3-cycle high glitch on bit 5 -> DATA stays 0, no capture; 10-cycle pulse -> DATA bit5=1 exactly 5 cycles after sync rises, capture bit5 set.
REQ-032 FALL_EN=0x80, RISE_EN=0; bit 7 1->0 -> capture 0x80; bit 7 0->1 -> no capture.
REQ-033 Capture=0x3, write 0x1 to addr 3 same cycle as a new bit-0 edge -> capture stays 0x3; next write 0x1 with no edge -> 0x2.
REQ-034 Preload EVENT_COUNT to 0xFFFF via 65535 edges, one more edge -> stays 0xFFFF; write addr 6 -> reads 0 next read.
REQ-035 Assert reset mid-debounce (cnt=2, DEBOUNCE=8) -> all registers at REQ-025 values immediately, irq=0, readdata=0.
